// File: rtl/associative_memory_multi.sv
// Multi-modality, multi-channel associative memory.
// Majority-bundled query, chunked Hamming search over writable prototypes.
module associative_memory_multi #(
  parameter int HV_DIMENSION   = 2048,
  parameter int AM_CHUNK       = 256,
  parameter int CLASSES        = 4,
  parameter int CHANNELS       = 2,
  parameter int MODALITIES     = 3,
  parameter int LABEL_WIDTH    = $clog2(CLASSES),
  parameter int DISTANCE_WIDTH = $clog2(HV_DIMENSION + 1),
  parameter int CHANNEL_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                Clk_CI,
  input  logic                                Reset_RBI,
  input  logic                                ValidIn_SI,
  output logic                                ReadyOut_SO,
  input  logic [MODALITIES*HV_DIMENSION-1:0]  HypervectorIn_DI,
  output logic                                ValidOut_SO,
  input  logic                                ReadyIn_SI,
  output logic [CHANNELS*LABEL_WIDTH-1:0]     LabelOut_DO,
  output logic [CHANNELS*DISTANCE_WIDTH-1:0]  DistanceOut_DO,
  input  logic                                ProtoWrEn_SI,
  input  logic [CHANNEL_WIDTH-1:0]            ProtoWrChannel_SI,
  input  logic [LABEL_WIDTH-1:0]              ProtoWrClass_SI,
  input  logic [HV_DIMENSION-1:0]             ProtoWrData_DI,
  output logic                                ProtoWrReady_SO
);

  localparam int NCHUNK  = HV_DIMENSION / AM_CHUNK;
  localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int POP_W   = $clog2(AM_CHUNK + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, OUTPUT} state_t;

  state_t state, stateNext;

  logic [HV_DIMENSION-1:0] query, bundled;
  logic [CHUNK_W-1:0]      chunkCnt;
  logic [LABEL_WIDTH-1:0]  classCnt;
  logic                    accept, searching, wrFire;
  logic                    lastChunk, lastClass;
  logic [AM_CHUNK-1:0]     qChunk;

  function automatic logic majority(input logic [MODALITIES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MODALITIES; i++) n += int'(v[i]);
    return (2 * n > MODALITIES);
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [AM_CHUNK-1:0] v);
    logic [POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < AM_CHUNK; i++) s = s + POP_W'(v[i]);
    return s;
  endfunction

  for (genvar b = 0; b < HV_DIMENSION; b++) begin : g_bundle
    logic [MODALITIES-1:0] col;
    for (genvar m = 0; m < MODALITIES; m++) begin : g_col
      assign col[m] = HypervectorIn_DI[m*HV_DIMENSION+b];
    end
    assign bundled[b] = majority(col);
  end

  assign accept      = (state == IDLE) && ValidIn_SI;
  assign searching   = (state == SEARCH);
  assign wrFire      = (state == IDLE) && ProtoWrEn_SI;
  assign lastChunk   = (chunkCnt == CHUNK_W'(NCHUNK - 1));
  assign lastClass   = (classCnt == LABEL_WIDTH'(CLASSES - 1));
  assign qChunk      = query[chunkCnt*AM_CHUNK +: AM_CHUNK];
  assign ReadyOut_SO     = (state == IDLE);
  assign ProtoWrReady_SO = (state == IDLE);
  assign ValidOut_SO     = (state == OUTPUT);

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (ValidIn_SI) stateNext = SEARCH;
      SEARCH:  if (lastChunk && lastClass) stateNext = OUTPUT;
      OUTPUT:  if (ReadyIn_SI) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      state    <= IDLE;
      query    <= '0;
      chunkCnt <= '0;
      classCnt <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        query    <= bundled;
        chunkCnt <= '0;
        classCnt <= '0;
      end else if (searching) begin
        if (lastChunk) begin
          chunkCnt <= '0;
          classCnt <= classCnt + 1'b1;
        end else begin
          chunkCnt <= chunkCnt + 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [HV_DIMENSION-1:0]   protoMem [CLASSES];
    logic [AM_CHUNK-1:0]       pChunk;
    logic [DISTANCE_WIDTH-1:0] accum, fullDist, bestDist, nextDist, outDist;
    logic [LABEL_WIDTH-1:0]    bestLabel, nextLabel, outLabel;
    logic                      takeBest, wrHit;

    assign pChunk   = protoMem[classCnt][chunkCnt*AM_CHUNK +: AM_CHUNK];
    assign fullDist = accum + DISTANCE_WIDTH'(popcount(qChunk ^ pChunk));
    // Class 0 seeds the best; later classes win only when strictly closer
    assign takeBest  = (classCnt == '0) || (fullDist < bestDist);
    assign nextDist  = takeBest ? fullDist : bestDist;
    assign nextLabel = takeBest ? classCnt : bestLabel;
    assign wrHit     = wrFire
                    && (ProtoWrChannel_SI == CHANNEL_WIDTH'(c))
                    && (32'(ProtoWrClass_SI) < 32'(CLASSES));

    assign LabelOut_DO[c*LABEL_WIDTH +: LABEL_WIDTH]          = outLabel;
    assign DistanceOut_DO[c*DISTANCE_WIDTH +: DISTANCE_WIDTH] = outDist;

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
        for (int k = 0; k < CLASSES; k++) protoMem[k] <= '0;
      end else if (wrHit) begin
        protoMem[ProtoWrClass_SI] <= ProtoWrData_DI;
      end
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
        accum     <= '0;
        bestDist  <= '0;
        bestLabel <= '0;
        outDist   <= '0;
        outLabel  <= '0;
      end else if (accept) begin
        accum <= '0;
      end else if (searching) begin
        if (lastChunk) begin
          accum     <= '0;
          bestDist  <= nextDist;
          bestLabel <= nextLabel;
          if (lastClass) begin
            outDist  <= nextDist;
            outLabel <= nextLabel;
          end
        end else begin
          accum <= fullDist;
        end
      end
    end
  end

endmodule

// File: tb/tb_associative_memory_multi.sv
// Bench for associative_memory_multi: directed plan plus random queries
// against a bit-counting reference model.
module tb_associative_memory_multi;

  localparam int HV = 16;
  localparam int CK = 4;
  localparam int CL = 4;
  localparam int NC = 2;
  localparam int M  = 3;
  localparam int LW = 2;
  localparam int DW = 5;
  localparam int LAT = CL * (HV / CK);

  logic            clk = 1'b0;
  logic            rstN;
  logic            validIn, readyOut, validOut, readyIn;
  logic [M*HV-1:0] hvIn;
  logic [NC*LW-1:0] labelOut;
  logic [NC*DW-1:0] distOut;
  logic            wrEn, wrReady;
  logic [0:0]      wrCh;
  logic [LW-1:0]   wrCls;
  logic [HV-1:0]   wrData;

  logic [HV-1:0] proto [NC][CL];
  int            expLabel [NC];
  int            expDist  [NC];
  int            nAsserts = 0;
  int            nFail = 0;

  always #5 clk = ~clk;

  associative_memory_multi #(
    .HV_DIMENSION(HV), .AM_CHUNK(CK), .CLASSES(CL),
    .CHANNELS(NC), .MODALITIES(M)
  ) dut (
    .Clk_CI(clk), .Reset_RBI(rstN),
    .ValidIn_SI(validIn), .ReadyOut_SO(readyOut),
    .HypervectorIn_DI(hvIn),
    .ValidOut_SO(validOut), .ReadyIn_SI(readyIn),
    .LabelOut_DO(labelOut), .DistanceOut_DO(distOut),
    .ProtoWrEn_SI(wrEn), .ProtoWrChannel_SI(wrCh),
    .ProtoWrClass_SI(wrCls), .ProtoWrData_DI(wrData),
    .ProtoWrReady_SO(wrReady)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [HV-1:0] bundleRef(input logic [M*HV-1:0] hv);
    logic [HV-1:0] r;
    for (int b = 0; b < HV; b++) begin
      int ones = 0;
      for (int m = 0; m < M; m++) ones += int'(hv[m*HV+b]);
      r[b] = (ones > M / 2);
    end
    return r;
  endfunction

  task automatic predict(input logic [M*HV-1:0] hv);
    logic [HV-1:0] q = bundleRef(hv);
    for (int c = 0; c < NC; c++) begin
      expDist[c]  = HV + 1;
      expLabel[c] = 0;
      for (int k = 0; k < CL; k++) begin
        int d = $countones(q ^ proto[c][k]);
        if (d < expDist[c]) begin
          expDist[c]  = d;
          expLabel[c] = k;
        end
      end
    end
  endtask

  task automatic checkResult(input string tag);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("%s_lab%0d", tag, c), 32'(labelOut[c*LW +: LW]),
            32'(expLabel[c]));
      check($sformatf("%s_dist%0d", tag, c), 32'(distOut[c*DW +: DW]),
            32'(expDist[c]));
    end
  endtask

  task automatic writeProto(input int ch, input int cls,
                            input logic [HV-1:0] d, input bit takes);
    @(negedge clk);
    wrEn = 1'b1; wrCh = 1'(ch); wrCls = LW'(cls); wrData = d;
    @(negedge clk);
    wrEn = 1'b0;
    if (takes) proto[ch][cls] = d;
  endtask

  // Issues a query (optionally with a same-cycle write) and waits for result
  task automatic runQuery(input string tag, input logic [M*HV-1:0] hv,
                          input bit withWr, input int ch, input int cls,
                          input logic [HV-1:0] d);
    int n = 0;
    while (!readyOut && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(readyOut), 32'd1);
    validIn = 1'b1;
    hvIn = hv;
    if (withWr) begin
      wrEn = 1'b1; wrCh = 1'(ch); wrCls = LW'(cls); wrData = d;
      proto[ch][cls] = d;
    end
    predict(hv);
    @(negedge clk);
    validIn = 1'b0;
    wrEn = 1'b0;
    n = 0;
    while (!validOut && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    checkResult(tag);
  endtask

  task automatic release1();
    readyIn = 1'b1;
    @(negedge clk);
    readyIn = 1'b0;
    check("release_idle", 32'(readyOut), 32'd1);
  endtask

  initial begin
    logic [LW-1:0] holdLab;
    logic [DW-1:0] holdDist;
    rstN = 1'b0; validIn = 1'b0; readyIn = 1'b0; hvIn = '0;
    wrEn = 1'b0; wrCh = '0; wrCls = '0; wrData = '0;
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < CL; k++) proto[c][k] = '0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // 1: reset state
    check("rst_vout", 32'(validOut), 32'd0);
    check("rst_rdy", 32'(readyOut), 32'd1);
    check("rst_wrrdy", 32'(wrReady), 32'd1);
    check("rst_lab", 32'(labelOut), 32'd0);
    check("rst_dist", 32'(distOut), 32'd0);

    // 2: exact match on ch0 class 2
    for (int k = 0; k < CL; k++)
      writeProto(0, k, (k == 2) ? 16'hA5A5 : 16'h5A5A, 1'b1);
    runQuery("t2", {3{16'hA5A5}}, 1'b0, 0, 0, '0);
    check("t2_lab0_abs", 32'(labelOut[0 +: LW]), 32'd2);
    check("t2_dist1_abs", 32'(distOut[DW +: DW]), 32'd8);
    release1();

    // 3: majority bundling, all-zero prototypes, tie keeps label 0
    for (int k = 0; k < CL; k++) writeProto(0, k, 16'h0000, 1'b1);
    runQuery("t3", {16'h0F0F, 16'h00FF, 16'hFFFF}, 1'b0, 0, 0, '0);
    check("t3_dist0_abs", 32'(distOut[0 +: DW]), 32'd12);
    release1();

    // 4: distances 5,3,7,3; class 3 written in the accept cycle
    writeProto(0, 0, 16'h001F, 1'b1);
    writeProto(0, 1, 16'h0007, 1'b1);
    writeProto(0, 2, 16'h007F, 1'b1);
    runQuery("t4", '0, 1'b1, 0, 3, 16'h0700);
    check("t4_lab0_abs", 32'(labelOut[0 +: LW]), 32'd1);
    check("t4_dist0_abs", 32'(distOut[0 +: DW]), 32'd3);

    // 5: backpressure hold; a write during OUTPUT must be dropped
    holdLab = labelOut[0 +: LW];
    holdDist = distOut[0 +: DW];
    wrEn = 1'b1; wrCh = 1'b0; wrCls = 2'd0; wrData = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_vout", 32'(validOut), 32'd1);
      check("t5_rdy", 32'(readyOut), 32'd0);
      check("t5_wrrdy", 32'(wrReady), 32'd0);
      check("t5_lab", 32'(labelOut[0 +: LW]), 32'(holdLab));
      check("t5_dist", 32'(distOut[0 +: DW]), 32'(holdDist));
    end
    wrEn = 1'b0;
    release1();
    check("t5_retain", 32'(labelOut[0 +: LW]), 32'(holdLab));
    runQuery("t5q", '0, 1'b0, 0, 0, '0);
    release1();

    // 6: asynchronous reset mid-search
    hvIn = {3{16'hFFFF}};
    validIn = 1'b1;
    @(negedge clk);
    validIn = 1'b0;
    repeat (6) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    check("t6_vout", 32'(validOut), 32'd0);
    check("t6_lab", 32'(labelOut), 32'd0);
    check("t6_dist", 32'(distOut), 32'd0);
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < CL; k++) proto[c][k] = '0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    runQuery("t6q", {3{16'h0F0F}}, 1'b0, 0, 0, '0);
    check("t6_dist1_abs", 32'(distOut[DW +: DW]), 32'd8);
    release1();

    // random prototypes and modality inputs
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < NC; c++)
        for (int k = 0; k < CL; k++)
          writeProto(c, k, 16'($urandom), 1'b1);
      runQuery($sformatf("rnd%0d", it), 48'({$urandom, $urandom}),
               1'b0, 0, 0, '0);
      release1();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFail);
    $finish;
  end

endmodule
